// File: rtl/mmio_tag_sched.sv
// Tag allocator and response sequencer for the MMIO completion tag tracker (tag-indexed RAM mode).
// Header info is an opaque vector; only the tag field at [TAG_LSB +: TAG_W] is rewritten.
`timescale 1ns/1ps
module mmio_tag_sched #(
  parameter int NUM_TAGS           = 32,
  parameter int MAX_OUTST          = 32,
  parameter int DATA_W             = 64,
  parameter int TAG_W              = 10,
  parameter int CPL_HDR_INFO_WIDTH = 64,
  parameter int TAG_LSB            = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CPL_HDR_INFO_WIDTH-1:0] req_info,
  output logic [TAG_W-1:0]              req_tag,
  output logic                          o_ctt_we,
  output logic [CPL_HDR_INFO_WIDTH-1:0] o_ctt_din,
  output logic                          o_ctt_re,
  output logic [TAG_W-1:0]              o_ctt_raddr,
  input  logic                          i_ctt_dout_valid,
  input  logic [CPL_HDR_INFO_WIDTH-1:0] i_ctt_dout,
  input  logic                          rsp_valid,
  output logic                          rsp_ready,
  input  logic [TAG_W-1:0]              rsp_tag,
  input  logic [DATA_W-1:0]             rsp_data,
  output logic                          cpl_valid,
  input  logic                          cpl_ready,
  output logic [CPL_HDR_INFO_WIDTH-1:0] cpl_hdr,
  output logic [DATA_W-1:0]             cpl_data,
  output logic [TAG_W:0]                outst_cnt,
  output logic                          err_unexp_tag
);

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_CPL} state_e;

  state_e                        state_q, state_d;
  logic [NUM_TAGS-1:0]           busy_q, busy_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [TAG_W-1:0]              tag_q, tag_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic [CPL_HDR_INFO_WIDTH-1:0] hdr_q, hdr_d;
  logic                          err_q, err_d;

  logic             any_free;
  logic [IDX_W-1:0] free_idx;
  logic             req_hs, rsp_hs, cpl_hs, rsp_known;

  // Lowest free tag wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign req_tag   = TAG_W'(free_idx);
  assign req_ready = rst_n && any_free && (cnt_q < CNT_W'(MAX_OUTST));
  assign req_hs    = req_valid && req_ready;
  assign o_ctt_we  = req_hs;

  always_comb begin
    o_ctt_din                    = req_info;
    o_ctt_din[TAG_LSB +: TAG_W]  = req_tag;
  end

  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_known = ({1'b0, rsp_tag} < CNT_W'(NUM_TAGS)) && busy_q[rsp_tag[IDX_W-1:0]];
  assign cpl_hs    = cpl_valid && cpl_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rsp_hs && rsp_known) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_WAIT;
      S_WAIT:   if (i_ctt_dout_valid) state_d = S_CPL;
      S_CPL:    if (cpl_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; rsp_ready is also held low while reset is asserted.
  always_comb begin
    rsp_ready = 1'b0;
    o_ctt_re  = 1'b0;
    cpl_valid = 1'b0;
    case (state_q)
      S_IDLE:   rsp_ready = rst_n;
      S_LOOKUP: o_ctt_re  = 1'b1;
      S_CPL:    cpl_valid = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next-state: the alloc and free tags never collide, since alloc reads registered busy.
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    hdr_d  = hdr_q;
    err_d  = 1'b0;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (rsp_hs) begin
      if (rsp_known) begin
        tag_d  = rsp_tag;
        data_d = rsp_data;
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == S_WAIT && i_ctt_dout_valid) hdr_d = i_ctt_dout;
    if (cpl_hs) busy_d[tag_q[IDX_W-1:0]] = 1'b0;
    if (req_hs) busy_d[free_idx] = 1'b1;
    case ({req_hs, cpl_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
      hdr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      hdr_q  <= hdr_d;
      err_q  <= err_d;
    end
  end

  assign o_ctt_raddr   = tag_q;
  assign cpl_hdr       = hdr_q;
  assign cpl_data      = data_q;
  assign outst_cnt     = cnt_q;
  assign err_unexp_tag = err_q;

endmodule

// File: tb/tb_mmio_tag_sched.sv
// Scoreboard bench for mmio_tag_sched: tag-set reference model, tracker RAM model, random traffic.
`timescale 1ns/1ps
module tb_mmio_tag_sched;
  localparam int NT = 32, MO = 32, DW = 64, TW = 10, HW = 64, TL = 0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, o_ctt_we, o_ctt_re, trk_vld, rsp_valid = 1'b0, rsp_ready;
  logic cpl_valid, cpl_ready = 1'b0, err_unexp_tag;
  logic [HW-1:0] req_info = '0, o_ctt_din, trk_dout, cpl_hdr;
  logic [TW-1:0] req_tag, o_ctt_raddr, rsp_tag = '0;
  logic [DW-1:0] rsp_data = '0, cpl_data;
  logic [TW:0]   outst_cnt;

  // second instance with a small outstanding cap
  logic r4_valid = 1'b0, r4_ready, r4_we, r4_re, r4_rrdy, r4_cv, r4_err;
  logic [HW-1:0] r4_din, r4_hdr;
  logic [TW-1:0] r4_tag, r4_raddr;
  logic [DW-1:0] r4_data;
  logic [TW:0]   r4_cnt;

  always #5 clk = ~clk;

  mmio_tag_sched #(.NUM_TAGS(NT), .MAX_OUTST(MO), .DATA_W(DW), .TAG_W(TW),
                   .CPL_HDR_INFO_WIDTH(HW), .TAG_LSB(TL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_info(req_info),
    .req_tag(req_tag), .o_ctt_we(o_ctt_we), .o_ctt_din(o_ctt_din), .o_ctt_re(o_ctt_re),
    .o_ctt_raddr(o_ctt_raddr), .i_ctt_dout_valid(trk_vld), .i_ctt_dout(trk_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_hdr(cpl_hdr), .cpl_data(cpl_data),
    .outst_cnt(outst_cnt), .err_unexp_tag(err_unexp_tag));

  mmio_tag_sched #(.NUM_TAGS(NT), .MAX_OUTST(4), .DATA_W(DW), .TAG_W(TW),
                   .CPL_HDR_INFO_WIDTH(HW), .TAG_LSB(TL)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(r4_valid), .req_ready(r4_ready), .req_info(req_info),
    .req_tag(r4_tag), .o_ctt_we(r4_we), .o_ctt_din(r4_din), .o_ctt_re(r4_re),
    .o_ctt_raddr(r4_raddr), .i_ctt_dout_valid(1'b0), .i_ctt_dout('0),
    .rsp_valid(1'b0), .rsp_ready(r4_rrdy), .rsp_tag('0), .rsp_data('0),
    .cpl_valid(r4_cv), .cpl_ready(1'b0), .cpl_hdr(r4_hdr), .cpl_data(r4_data),
    .outst_cnt(r4_cnt), .err_unexp_tag(r4_err));

  typedef struct { logic [HW-1:0] hdr; logic [DW-1:0] data; int due; } exp_t;
  exp_t          sbq[$];
  bit            alloc[NT];
  logic [HW-1:0] exp_hdr[NT];
  int            outst = 0;
  bit            rsp_busy = 1'b0;
  bit            err_exp[int];
  int            re_exp[int];
  int            cyc = 0;
  int            vectors = 0, miscompares = 0;
  bit            cont_cv = 1'b0;

  // Tracker RAM: answers a read strobe with data on the following cycle.
  logic [HW-1:0] trk_mem[NT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld  <= 1'b0;
      trk_dout <= '0;
    end else begin
      if (o_ctt_we) trk_mem[o_ctt_din[TL+4:TL]] <= o_ctt_din;
      trk_vld  <= o_ctt_re;
      trk_dout <= trk_mem[o_ctt_raddr[4:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [HW-1:0] mk(input logic [15:0] rid);
    logic [HW-1:0] h;
    h = {$urandom, $urandom};
    h[31:16] = rid;
    return h;
  endfunction

  function automatic logic [TW-1:0] pick_tag();
    int s;
    if ($urandom_range(9) == 0) return TW'($urandom_range(63));
    s = $urandom_range(NT - 1);
    for (int k = 0; k < NT; k++) if (alloc[(s + k) % NT]) return TW'((s + k) % NT);
    return TW'(s);
  endfunction

  // One stimulus cycle: drive at negedge, check the predicted handshake view, update model.
  task automatic drive(input bit rv, input logic [HW-1:0] info, input bit sv,
                       input logic [TW-1:0] st, input logic [DW-1:0] sd, input bit cr);
    int lf;
    bit erdy;
    logic [HW-1:0] h;
    @(negedge clk);
    req_valid = rv; req_info = info; rsp_valid = sv; rsp_tag = st; rsp_data = sd; cpl_ready = cr;
    #1;
    lf = -1;
    for (int i = NT - 1; i >= 0; i--) if (!alloc[i]) lf = i;
    erdy = (lf >= 0) && (outst < MO);
    chk("outst_cnt", outst_cnt, outst);
    chk("req_ready", req_ready, erdy);
    if (erdy) chk("req_tag", req_tag, lf);
    chk("ctt_we", o_ctt_we, rv && erdy);
    chk("rsp_ready", rsp_ready, !rsp_busy);
    if (sv && !rsp_busy) begin
      if (st < NT && alloc[st]) begin
        rsp_busy = 1'b1;
        sbq.push_back(exp_t'{exp_hdr[st], sd, cyc + 3});
        re_exp[cyc + 1] = int'(st);
      end else begin
        err_exp[cyc + 1] = 1'b1;
      end
    end
    if (rv && erdy) begin
      h = info;
      h[TL +: TW] = TW'(lf);
      chk("ctt_din", o_ctt_din, h);
      alloc[lf] = 1'b1;
      exp_hdr[lf] = h;
      outst++;
    end
  endtask

  task automatic idle(input int n, input bit cr);
    repeat (n) drive(1'b0, '0, 1'b0, '0, '0, cr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0; cpl_ready = 1'b0; r4_valid = 1'b0;
    for (int i = 0; i < NT; i++) alloc[i] = 1'b0;
    outst = 0; rsp_busy = 1'b0;
    sbq.delete(); err_exp.delete(); re_exp.delete();
    #1;
    chk("rst_cpl_valid", cpl_valid, 1'b0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_ctt_re", o_ctt_re, 1'b0);
    chk("rst_err", err_unexp_tag, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sampled well clear of the rising edge, after the stimulus has settled.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      chk("err_unexp_tag", err_unexp_tag, err_exp.exists(cyc));
      chk("ctt_re", o_ctt_re, re_exp.exists(cyc));
      if (re_exp.exists(cyc)) chk("ctt_raddr", o_ctt_raddr, re_exp[cyc]);
      if (cpl_valid) begin
        if (sbq.size() == 0) begin
          chk("cpl_unexpected", cpl_valid, 1'b0);
        end else begin
          chk("cpl_hdr", cpl_hdr, sbq[0].hdr);
          chk("cpl_data", cpl_data, sbq[0].data);
          if (!cont_cv) chk("cpl_latency", cyc, sbq[0].due);
          if (cpl_ready) begin
            alloc[sbq[0].hdr[TL +: 5]] = 1'b0;
            outst--;
            rsp_busy = 1'b0;
            void'(sbq.pop_front());
          end
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("cpl_missing", cpl_valid, 1'b1);
        alloc[sbq[0].hdr[TL +: 5]] = 1'b0;
        outst--;
        rsp_busy = 1'b0;
        void'(sbq.pop_front());
      end
      cont_cv = cpl_valid && !cpl_ready;
    end else begin
      cont_cv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NT; i++) begin alloc[i] = 1'b0; exp_hdr[i] = '0; trk_mem[i] = '0; end
    // reset state, with a request already presented
    req_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_ctt_we", o_ctt_we, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_cpl_valid", cpl_valid, 1'b0);
    chk("rst_raddr", o_ctt_raddr, 0);
    chk("rst_cpl_hdr", cpl_hdr, 0);
    chk("rst_cpl_data", cpl_data, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_err", err_unexp_tag, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // small cap: four grants, then stalled with plenty of free tags
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r4_valid = 1'b1;
      #1;
      chk("max4_ready", r4_ready, k < 4);
      chk("max4_cnt", r4_cnt, (k < 4) ? k : 4);
      if (k < 4) chk("max4_tag", r4_tag, k);
    end
    @(negedge clk);
    r4_valid = 1'b0;

    // single read
    drive(1'b1, mk(16'h0100), 1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 10'd0, 64'hA5, 1'b1);
    idle(5, 1'b1);

    // fill all tags, overflow attempt, free tag 5 and reuse it
    for (int k = 0; k < NT; k++) drive(1'b1, mk(16'($urandom)), 1'b0, '0, '0, 1'b0);
    drive(1'b1, mk(16'h1234), 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 10'd5, 64'hDEAD_BEEF, 1'b1);
    idle(4, 1'b1);
    drive(1'b1, mk(16'h0555), 1'b0, '0, '0, 1'b1);
    do_reset();

    // unexpected tag
    drive(1'b0, '0, 1'b1, 10'd7, 64'h77, 1'b1);
    idle(4, 1'b1);

    // backpressure, then same-cycle request and completion
    drive(1'b1, mk(16'h0A00), 1'b0, '0, '0, 1'b0);
    drive(1'b1, mk(16'h0A01), 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 10'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (12) drive(1'b0, '0, 1'b1, 10'd1, 64'h55, 1'b0);
    drive(1'b1, mk(16'h0A02), 1'b0, '0, '0, 1'b1);
    idle(2, 1'b1);
    do_reset();

    // reset while waiting for tracker data
    drive(1'b1, mk(16'h0B00), 1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 10'd0, 64'h99, 1'b1);
    idle(1, 1'b1);
    do_reset();
    drive(1'b1, mk(16'h0B01), 1'b0, '0, '0, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++)
      drive($urandom_range(3) == 0, mk(16'($urandom)), $urandom_range(1) == 1, pick_tag(),
            {$urandom, $urandom}, $urandom_range(3) != 0);
    idle(10, 1'b1);
    chk("drain_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
